tlb_mmu: RTL and testbench
==========================

Name: tlb_mmu

Overview:
- Parametrised successor to the fixed-mapping MMU.
- kseg0 and kseg1 keep their direct mapping. kuseg, kseg2 and kseg3 are translated through a fully associative, software-managed, MIPS32-style joint TLB.
- Two lookup ports (instruction fetch, data access) share the TLB. The block also services CP0 TLBWI/TLBWR writes, TLBR reads and TLBP probes.
- Sits between the IF/MEM address paths and the cache/AXI bridge. Every lookup result is registered with a fixed 1-cycle latency.

Parameters:
- TLB_ENTRIES, 16, number of entries; power of two, 4..64.
- IDX_W, $clog2(TLB_ENTRIES), width of the index fields.
- ASID_W, 8, ASID width.

Ports:
- cpu_clk_50M  in  1  clock.
- cpu_rst_n  in  1  asynchronous, active-low reset.
- inst_req  in  1  instruction lookup strobe.
- inst_vaddr  in  32  instruction virtual address.
- inst_paddr  out  32  instruction physical address, registered.
- inst_uncached  out  1  instruction access is uncached.
- inst_refill  out  1  TLB miss on the instruction port.
- inst_invalid  out  1  hit on an entry whose V bit is 0.
- data_req  in  1  data lookup strobe.
- data_we  in  1  data access is a store.
- data_vaddr  in  32  data virtual address.
- data_paddr  out  32  data physical address, registered.
- data_uncached  out  1  data access is uncached.
- data_refill  out  1  TLB miss on the data port.
- data_invalid  out  1  hit on an entry whose V bit is 0.
- data_modified  out  1  store hit on an entry whose D bit is 0.
- cp0_asid  in  ASID_W  current EntryHi.ASID.
- cp0_k0  in  3  Config.K0 field.
- tlbw_en  in  1  write strobe.
- tlbw_idx  in  IDX_W  write index.
- tlb_entryhi  in  32  VPN2[31:13], ASID[ASID_W-1:0].
- tlb_entrylo0  in  32  PFN[25:6], C[5:3], D[2], V[1], G[0].
- tlb_entrylo1  in  32  same layout as entrylo0, for the odd page.
- tlbr_en  in  1  read strobe.
- tlbr_idx  in  IDX_W  read index.
- tlbr_entryhi  out  32  read-back EntryHi, registered.
- tlbr_entrylo0  out  32  read-back EntryLo0, registered.
- tlbr_entrylo1  out  32  read-back EntryLo1, registered.
- tlbp_en  in  1  probe strobe; uses tlb_entryhi.
- tlbp_miss  out  1  probe found no match; becomes Index.P.
- tlbp_idx  out  IDX_W  index of the matching entry.

Behaviour:
- Reset:
  - All entries cleared: VPN2, ASID, PFN, C, D, V, G all 0.
  - All outputs 0, except tlbp_miss=1.
- Segment decode on vaddr[31:28]:
  - 8..9 (kseg0): paddr = {3'b000, vaddr[28:0]}; uncached = (cp0_k0 == 3'd2).
  - a..b (kseg1): paddr = {3'b000, vaddr[28:0]}; uncached = 1.
  - All other values: mapped through the TLB.
  - Unmapped addresses never raise refill, invalid or modified.
- Match rule: entry i matches when VPN2_i == vaddr[31:13] and (G_i or ASID_i == cp0_asid).
  - vaddr[12] selects the page: 0 selects lo0, 1 selects lo1.
  - If several entries match, the lowest index wins.
- Mapped result:
  - paddr = {PFN_sel[19:0], vaddr[11:0]}.
  - uncached = (C_sel == 3'd2).
  - No match: refill=1, paddr=0.
  - Match with V_sel=0: invalid=1.
  - Data port store (data_we=1) matching with V_sel=1 and D_sel=0: modified=1.
  - At most one fault flag is asserted per port; priority is refill > invalid > modified.
- Latency:
  - A lookup with req=1 at edge N presents its results in cycle N+1.
  - Outputs hold until the next req on that port.
  - Each port registers independently; both ports may look up in the same cycle.
- Write:
  - tlbw_en at edge N updates entry tlbw_idx at that edge.
  - G is stored as (lo0.G & lo1.G).
  - A lookup or probe in the same cycle as a write uses the pre-write contents.
  - Lookups from cycle N+1 onward see the new entry.
- Read:
  - tlbr_en at edge N loads the tlbr_* outputs by cycle N+1.
  - Read-back G appears in bit 0 of both entrylo0 and entrylo1.
  - Unused bits read as 0.
- Probe:
  - tlbp_en at edge N: in cycle N+1, tlbp_miss=0 and tlbp_idx = lowest matching index; otherwise tlbp_miss=1 and tlbp_idx=0.
  - The probe uses tlb_entryhi's VPN2 and ASID, not cp0_asid.
- Reset mid-operation: asynchronous clear of all entries and outputs, regardless of any pending strobe.

Test Plan:
- Unmapped segments: inst lookup of 0xBFC00000 -> paddr 0x1FC00000, uncached=1. With cp0_k0=3, data lookup of 0x80001234 -> paddr 0x00001234, uncached=0. With cp0_k0=2, the same lookup -> uncached=1.
- Empty TLB: data lookup of 0x00400000 after reset -> data_refill=1 one cycle later. Probe with entryhi 0x00400000 -> tlbp_miss=1.
- Write then translate (both ports in the same cycle):
  - Write idx 3: entryhi 0x00400005, lo0 PFN 0x12345 with C=3, D=1, V=1; lo1 V=0.
  - Set cp0_asid=5.
  - Inst lookup of 0x00400abc -> paddr 0x12345abc, uncached=0.
  - Data lookup of 0x00401000 -> data_invalid=1.
- ASID and global:
  - Same entry as above, cp0_asid=6 -> refill.
  - Rewrite idx 3 with G=1 in both lo0 and lo1 -> hit with paddr 0x12345abc.
  - Data store to a page with D=0 -> data_modified=1 only.
- Hazard, priority and probe:
  - Write idx 7 and look up its VPN in the same cycle -> refill. The next lookup -> hit.
  - Duplicate VPN at idx 2 and idx 9 -> idx 2 PFN used, and a probe returns tlbp_idx=2.
- Read-back and reset:
  - TLBR idx 3 -> the written entryhi/entrylo values, with G reflected in bit 0.
  - Assert cpu_rst_n=0 mid-lookup -> outputs clear immediately. A subsequent lookup -> refill.

Source files
------------

// File: rtl/tlb_mmu_if.sv
// Lookup, CP0 TLB maintenance and result bundle between the pipeline and the MMU.
// The master side (pipeline / CP0) drives requests; the slave side (MMU) returns
// registered translation results, read-back entries and probe results.
interface tlb_mmu_if #(
    parameter int TLB_ENTRIES = 16,
    parameter int IDX_W       = $clog2(TLB_ENTRIES),
    parameter int ASID_W      = 8
);
    logic              inst_req;
    logic [31:0]       inst_vaddr;
    logic [31:0]       inst_paddr;
    logic              inst_uncached;
    logic              inst_refill;
    logic              inst_invalid;

    logic              data_req;
    logic              data_we;
    logic [31:0]       data_vaddr;
    logic [31:0]       data_paddr;
    logic              data_uncached;
    logic              data_refill;
    logic              data_invalid;
    logic              data_modified;

    logic [ASID_W-1:0] cp0_asid;
    logic [2:0]        cp0_k0;

    logic              tlbw_en;
    logic [IDX_W-1:0]  tlbw_idx;
    logic [31:0]       tlb_entryhi;
    logic [31:0]       tlb_entrylo0;
    logic [31:0]       tlb_entrylo1;

    logic              tlbr_en;
    logic [IDX_W-1:0]  tlbr_idx;
    logic [31:0]       tlbr_entryhi;
    logic [31:0]       tlbr_entrylo0;
    logic [31:0]       tlbr_entrylo1;

    logic              tlbp_en;
    logic              tlbp_miss;
    logic [IDX_W-1:0]  tlbp_idx;

    modport master (
        output inst_req, inst_vaddr, data_req, data_we, data_vaddr,
               cp0_asid, cp0_k0, tlbw_en, tlbw_idx, tlb_entryhi,
               tlb_entrylo0, tlb_entrylo1, tlbr_en, tlbr_idx, tlbp_en,
        input  inst_paddr, inst_uncached, inst_refill, inst_invalid,
               data_paddr, data_uncached, data_refill, data_invalid,
               data_modified, tlbr_entryhi, tlbr_entrylo0, tlbr_entrylo1,
               tlbp_miss, tlbp_idx
    );

    modport slave (
        input  inst_req, inst_vaddr, data_req, data_we, data_vaddr,
               cp0_asid, cp0_k0, tlbw_en, tlbw_idx, tlb_entryhi,
               tlb_entrylo0, tlb_entrylo1, tlbr_en, tlbr_idx, tlbp_en,
        output inst_paddr, inst_uncached, inst_refill, inst_invalid,
               data_paddr, data_uncached, data_refill, data_invalid,
               data_modified, tlbr_entryhi, tlbr_entrylo0, tlbr_entrylo1,
               tlbp_miss, tlbp_idx
    );
endinterface

// File: rtl/tlb_mmu.sv
// MIPS32-style MMU: kseg0/kseg1 are direct-mapped, everything else goes through
// a fully associative joint TLB shared by the instruction and data ports.
// All results are registered with one cycle of latency; lowest index wins on
// multiple matches. Writes take effect at the edge, so same-cycle lookups and
// probes see the old contents.
module tlb_mmu #(
    parameter int TLB_ENTRIES = 16,
    parameter int IDX_W       = $clog2(TLB_ENTRIES),
    parameter int ASID_W      = 8
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst_n,
    tlb_mmu_if.slave    bus
);

    typedef struct packed {
        logic [31:0] paddr;
        logic        uncached;
        logic        refill;
        logic        invalid;
        logic        modified;
    } xlate_t;

    logic [18:0]       r_vpn2 [TLB_ENTRIES];
    logic [ASID_W-1:0] r_asid [TLB_ENTRIES];
    logic              r_g    [TLB_ENTRIES];
    logic [19:0]       r_pfn0 [TLB_ENTRIES];
    logic [19:0]       r_pfn1 [TLB_ENTRIES];
    logic [2:0]        r_c0   [TLB_ENTRIES];
    logic [2:0]        r_c1   [TLB_ENTRIES];
    logic              r_d0   [TLB_ENTRIES];
    logic              r_d1   [TLB_ENTRIES];
    logic              r_v0   [TLB_ENTRIES];
    logic              r_v1   [TLB_ENTRIES];

    xlate_t            r_inst;
    xlate_t            r_data;
    logic [31:0]       r_tlbr_hi;
    logic [31:0]       r_tlbr_lo0;
    logic [31:0]       r_tlbr_lo1;
    logic              r_tlbp_miss;
    logic [IDX_W-1:0]  r_tlbp_idx;

    xlate_t            w_inst;
    xlate_t            w_data;
    logic [IDX_W:0]    w_probe;
    logic [31:0]       w_rd_hi;
    logic              w_unused;

    // Associative search: returns {miss, index}; scanning downwards leaves the lowest match.
    function automatic logic [IDX_W:0] f_match(input logic [18:0] vpn2, input logic [ASID_W-1:0] asid);
        logic [IDX_W:0] res;
        res = {1'b1, {IDX_W{1'b0}}};
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (r_vpn2[i] == vpn2 && (r_g[i] || r_asid[i] == asid))
                res = {1'b0, IDX_W'(i)};
        end
        return res;
    endfunction

    // Full translation of one virtual address including segment decode and fault priority.
    function automatic xlate_t f_xlate(input logic [31:0] va, input logic we,
                                       input logic [ASID_W-1:0] asid, input logic [2:0] k0);
        xlate_t           res;
        logic [IDX_W:0]   m;
        logic [IDX_W-1:0] idx;
        logic [19:0]      pfn;
        logic [2:0]       c;
        logic             d;
        logic             v;
        res = '0;
        m   = f_match(va[31:13], asid);
        idx = m[IDX_W-1:0];
        pfn = va[12] ? r_pfn1[idx] : r_pfn0[idx];
        c   = va[12] ? r_c1[idx]   : r_c0[idx];
        d   = va[12] ? r_d1[idx]   : r_d0[idx];
        v   = va[12] ? r_v1[idx]   : r_v0[idx];
        if (va[31:29] == 3'b100) begin
            res.paddr    = {3'b000, va[28:0]};
            res.uncached = (k0 == 3'd2);
        end else if (va[31:29] == 3'b101) begin
            res.paddr    = {3'b000, va[28:0]};
            res.uncached = 1'b1;
        end else if (m[IDX_W]) begin
            res.refill   = 1'b1;
        end else begin
            res.paddr    = {pfn, va[11:0]};
            res.uncached = (c == 3'd2);
            res.invalid  = ~v;
            res.modified = we & v & ~d;
        end
        return res;
    endfunction

    assign w_inst  = f_xlate(bus.inst_vaddr, 1'b0, bus.cp0_asid, bus.cp0_k0);
    assign w_data  = f_xlate(bus.data_vaddr, bus.data_we, bus.cp0_asid, bus.cp0_k0);
    assign w_probe = f_match(bus.tlb_entryhi[31:13], bus.tlb_entryhi[ASID_W-1:0]);

    // Read-back EntryHi: VPN2 and ASID in place, gap bits zero.
    always_comb begin
        w_rd_hi              = '0;
        w_rd_hi[31:13]       = r_vpn2[bus.tlbr_idx];
        w_rd_hi[ASID_W-1:0]  = r_asid[bus.tlbr_idx];
    end

    assign w_unused = ^{bus.tlb_entryhi[12:ASID_W], bus.tlb_entrylo0[31:26], bus.tlb_entrylo1[31:26]};

    // Entry storage: cleared on reset, one entry rewritten per TLBWI/TLBWR strobe.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            for (int i = 0; i < TLB_ENTRIES; i++) begin
                r_vpn2[i] <= '0;
                r_asid[i] <= '0;
                r_g[i]    <= 1'b0;
                r_pfn0[i] <= '0;
                r_pfn1[i] <= '0;
                r_c0[i]   <= '0;
                r_c1[i]   <= '0;
                r_d0[i]   <= 1'b0;
                r_d1[i]   <= 1'b0;
                r_v0[i]   <= 1'b0;
                r_v1[i]   <= 1'b0;
            end
        end else if (bus.tlbw_en) begin
            r_vpn2[bus.tlbw_idx] <= bus.tlb_entryhi[31:13];
            r_asid[bus.tlbw_idx] <= bus.tlb_entryhi[ASID_W-1:0];
            r_g[bus.tlbw_idx]    <= bus.tlb_entrylo0[0] & bus.tlb_entrylo1[0];
            r_pfn0[bus.tlbw_idx] <= bus.tlb_entrylo0[25:6];
            r_pfn1[bus.tlbw_idx] <= bus.tlb_entrylo1[25:6];
            r_c0[bus.tlbw_idx]   <= bus.tlb_entrylo0[5:3];
            r_c1[bus.tlbw_idx]   <= bus.tlb_entrylo1[5:3];
            r_d0[bus.tlbw_idx]   <= bus.tlb_entrylo0[2];
            r_d1[bus.tlbw_idx]   <= bus.tlb_entrylo1[2];
            r_v0[bus.tlbw_idx]   <= bus.tlb_entrylo0[1];
            r_v1[bus.tlbw_idx]   <= bus.tlb_entrylo1[1];
        end
    end

    // Result registers: each port, TLBR and TLBP update only on their own strobe and hold otherwise.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_inst      <= '0;
            r_data      <= '0;
            r_tlbr_hi   <= '0;
            r_tlbr_lo0  <= '0;
            r_tlbr_lo1  <= '0;
            r_tlbp_miss <= 1'b1;
            r_tlbp_idx  <= '0;
        end else begin
            if (bus.inst_req)
                r_inst <= w_inst;
            if (bus.data_req)
                r_data <= w_data;
            if (bus.tlbr_en) begin
                r_tlbr_hi  <= w_rd_hi;
                r_tlbr_lo0 <= {6'b0, r_pfn0[bus.tlbr_idx], r_c0[bus.tlbr_idx],
                               r_d0[bus.tlbr_idx], r_v0[bus.tlbr_idx], r_g[bus.tlbr_idx]};
                r_tlbr_lo1 <= {6'b0, r_pfn1[bus.tlbr_idx], r_c1[bus.tlbr_idx],
                               r_d1[bus.tlbr_idx], r_v1[bus.tlbr_idx], r_g[bus.tlbr_idx]};
            end
            if (bus.tlbp_en) begin
                r_tlbp_miss <= w_probe[IDX_W];
                r_tlbp_idx  <= w_probe[IDX_W] ? '0 : w_probe[IDX_W-1:0];
            end
        end
    end

    assign bus.inst_paddr    = r_inst.paddr;
    assign bus.inst_uncached = r_inst.uncached;
    assign bus.inst_refill   = r_inst.refill;
    assign bus.inst_invalid  = r_inst.invalid;
    assign bus.data_paddr    = r_data.paddr;
    assign bus.data_uncached = r_data.uncached;
    assign bus.data_refill   = r_data.refill;
    assign bus.data_invalid  = r_data.invalid;
    assign bus.data_modified = r_data.modified;
    assign bus.tlbr_entryhi  = r_tlbr_hi;
    assign bus.tlbr_entrylo0 = r_tlbr_lo0;
    assign bus.tlbr_entrylo1 = r_tlbr_lo1;
    assign bus.tlbp_miss     = r_tlbp_miss;
    assign bus.tlbp_idx      = r_tlbp_idx;

endmodule

// File: tb/tb_tlb_mmu.sv
// Bench for tlb_mmu: directed scenarios from the bring-up plan plus a randomized
// run checked against a behavioural TLB model that stores raw EntryHi/EntryLo words.
module tb_tlb_mmu;
    localparam int N  = 16;
    localparam int IW = 4;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    tlb_mmu_if #(.TLB_ENTRIES(N), .IDX_W(IW), .ASID_W(AW)) bus();

    tlb_mmu #(.TLB_ENTRIES(N), .IDX_W(IW), .ASID_W(AW)) dut (
        .cpu_clk_50M (clk),
        .cpu_rst_n   (rst_n),
        .bus         (bus)
    );

    // Reference TLB contents as software wrote them
    logic [31:0] m_hi  [N];
    logic [31:0] m_lo0 [N];
    logic [31:0] m_lo1 [N];

    // Expected registered outputs, grouped per function
    logic [34:0] e_inst;
    logic [35:0] e_data;
    logic [95:0] e_rd;
    logic [IW:0] e_pr;

    logic [34:0] a_inst;
    logic [35:0] a_data;
    logic [95:0] a_rd;
    logic [IW:0] a_pr;
    assign a_inst = {bus.inst_paddr, bus.inst_uncached, bus.inst_refill, bus.inst_invalid};
    assign a_data = {bus.data_paddr, bus.data_uncached, bus.data_refill, bus.data_invalid, bus.data_modified};
    assign a_rd   = {bus.tlbr_entryhi, bus.tlbr_entrylo0, bus.tlbr_entrylo1};
    assign a_pr   = {bus.tlbp_miss, bus.tlbp_idx};

    function automatic logic [31:0] lo(input logic [19:0] pfn, input logic [2:0] c,
                                       input logic d, input logic v, input logic g);
        return {6'b0, pfn, c, d, v, g};
    endfunction

    // First entry (lowest index) whose VPN2 matches and is global or shares the ASID; -1 if none
    function automatic int model_find(input logic [18:0] vpn2, input logic [7:0] asid);
        for (int i = 0; i < N; i++)
            if (m_hi[i][31:13] == vpn2 && ((m_lo0[i][0] && m_lo1[i][0]) || m_hi[i][7:0] == asid))
                return i;
        return -1;
    endfunction

    function automatic void model_lookup(input logic [31:0] va, input logic we, input logic [7:0] asid,
                                         input logic [2:0] k0, output logic [31:0] pa, output logic unc,
                                         output logic rf, output logic inv, output logic md);
        int          hit;
        logic [31:0] sel;
        pa = 32'h0; unc = 1'b0; rf = 1'b0; inv = 1'b0; md = 1'b0;
        if (va >= 32'h8000_0000 && va < 32'hA000_0000) begin
            pa = va - 32'h8000_0000; unc = (k0 == 3'd2);
        end else if (va >= 32'hA000_0000 && va < 32'hC000_0000) begin
            pa = va - 32'hA000_0000; unc = 1'b1;
        end else begin
            hit = model_find(va[31:13], asid);
            if (hit < 0) rf = 1'b1;
            else begin
                sel = va[12] ? m_lo1[hit] : m_lo0[hit];
                pa  = {sel[25:6], va[11:0]};
                unc = (sel[5:3] == 3'd2);
                if (!sel[1]) inv = 1'b1;
                else if (we && !sel[2]) md = 1'b1;
            end
        end
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_hi[i] = '0; m_lo0[i] = '0; m_lo1[i] = '0;
        end
        e_inst = '0; e_data = '0; e_rd = '0; e_pr = {1'b1, {IW{1'b0}}};
    endtask

    task automatic clear_strobes();
        bus.inst_req = 0; bus.data_req = 0; bus.data_we = 0;
        bus.tlbw_en = 0; bus.tlbr_en = 0; bus.tlbp_en = 0;
    endtask

    task automatic set_write(input logic [IW-1:0] idx, input logic [31:0] hi,
                             input logic [31:0] l0, input logic [31:0] l1);
        bus.tlbw_en = 1; bus.tlbw_idx = idx;
        bus.tlb_entryhi = hi; bus.tlb_entrylo0 = l0; bus.tlb_entrylo1 = l1;
    endtask

    // Predict from pre-edge model state, apply the write, advance one edge, drop strobes
    task automatic step();
        logic [31:0] pa;
        logic u, rf, iv, md, g;
        int hit;
        if (bus.inst_req) begin
            model_lookup(bus.inst_vaddr, 1'b0, bus.cp0_asid, bus.cp0_k0, pa, u, rf, iv, md);
            e_inst = {pa, u, rf, iv};
        end
        if (bus.data_req) begin
            model_lookup(bus.data_vaddr, bus.data_we, bus.cp0_asid, bus.cp0_k0, pa, u, rf, iv, md);
            e_data = {pa, u, rf, iv, md};
        end
        if (bus.tlbr_en) begin
            g = m_lo0[bus.tlbr_idx][0] & m_lo1[bus.tlbr_idx][0];
            e_rd = {m_hi[bus.tlbr_idx] & 32'hFFFF_E0FF,
                    6'b0, m_lo0[bus.tlbr_idx][25:1], g,
                    6'b0, m_lo1[bus.tlbr_idx][25:1], g};
        end
        if (bus.tlbp_en) begin
            hit  = model_find(bus.tlb_entryhi[31:13], bus.tlb_entryhi[7:0]);
            e_pr = (hit < 0) ? {1'b1, {IW{1'b0}}} : {1'b0, IW'(hit)};
        end
        if (bus.tlbw_en) begin
            m_hi[bus.tlbw_idx]  = bus.tlb_entryhi;
            m_lo0[bus.tlbw_idx] = bus.tlb_entrylo0;
            m_lo1[bus.tlbw_idx] = bus.tlb_entrylo1;
        end
        @(posedge clk); #1;
        clear_strobes();
    endtask

    task automatic test_reset();
        nvec++; if (a_inst !== 35'h0) begin nerr++; $display("[TB] FAIL reset_inst: got %h expected 0", a_inst); end
        nvec++; if (a_data !== 36'h0) begin nerr++; $display("[TB] FAIL reset_data: got %h expected 0", a_data); end
        nvec++; if (a_rd !== 96'h0) begin nerr++; $display("[TB] FAIL reset_tlbr: got %h expected 0", a_rd); end
        nvec++; if (a_pr !== 5'h10) begin nerr++; $display("[TB] FAIL reset_probe: got %h expected 10", a_pr); end
        bus.tlbr_en = 1; bus.tlbr_idx = 4'd5; step();
        nvec++; if (a_rd !== 96'h0) begin nerr++; $display("[TB] FAIL reset_entry: got %h expected 0", a_rd); end
    endtask

    task automatic test_unmapped();
        bus.cp0_k0 = 3'd3;
        bus.inst_req = 1; bus.inst_vaddr = 32'hBFC0_0000;
        bus.data_req = 1; bus.data_vaddr = 32'h8000_1234;
        step();
        nvec++; if (a_inst !== {32'h1FC0_0000, 3'b100}) begin nerr++; $display("[TB] FAIL kseg1_inst: got %h expected %h", a_inst, {32'h1FC0_0000, 3'b100}); end
        nvec++; if (a_data !== {32'h0000_1234, 4'b0000}) begin nerr++; $display("[TB] FAIL kseg0_cached: got %h expected %h", a_data, {32'h0000_1234, 4'b0000}); end
        bus.cp0_k0 = 3'd2; bus.data_req = 1; bus.data_vaddr = 32'h8000_1234; step();
        nvec++; if (a_data !== {32'h0000_1234, 4'b1000}) begin nerr++; $display("[TB] FAIL kseg0_uncached: got %h expected %h", a_data, {32'h0000_1234, 4'b1000}); end
        bus.cp0_k0 = 3'd3;
    endtask

    task automatic test_empty();
        bus.data_req = 1; bus.data_vaddr = 32'h0040_0000;
        bus.tlbp_en = 1; bus.tlb_entryhi = 32'h0040_0000;
        step();
        nvec++; if (a_data !== {32'h0, 4'b0100}) begin nerr++; $display("[TB] FAIL empty_refill: got %h expected %h", a_data, {32'h0, 4'b0100}); end
        nvec++; if (a_pr !== 5'h10) begin nerr++; $display("[TB] FAIL empty_probe: got %h expected 10", a_pr); end
    endtask

    task automatic test_write_translate();
        set_write(4'd3, 32'h0040_0005, lo(20'h12345, 3'd3, 1'b1, 1'b1, 1'b0), 32'h0);
        step();
        bus.cp0_asid = 8'd5;
        bus.inst_req = 1; bus.inst_vaddr = 32'h0040_0ABC;
        bus.data_req = 1; bus.data_vaddr = 32'h0040_1000;
        step();
        nvec++; if (a_inst !== {32'h1234_5ABC, 3'b000}) begin nerr++; $display("[TB] FAIL xlate_inst: got %h expected %h", a_inst, {32'h1234_5ABC, 3'b000}); end
        nvec++; if (a_data !== {32'h0, 4'b0010}) begin nerr++; $display("[TB] FAIL xlate_invalid: got %h expected %h", a_data, {32'h0, 4'b0010}); end
        bus.inst_vaddr = 32'hBFC0_0000; step();
        nvec++; if (a_inst !== {32'h1234_5ABC, 3'b000}) begin nerr++; $display("[TB] FAIL hold_inst: got %h expected %h", a_inst, {32'h1234_5ABC, 3'b000}); end
    endtask

    task automatic test_asid_global();
        bus.cp0_asid = 8'd6;
        bus.inst_req = 1; bus.inst_vaddr = 32'h0040_0ABC; step();
        nvec++; if (a_inst !== {32'h0, 3'b010}) begin nerr++; $display("[TB] FAIL asid_miss: got %h expected %h", a_inst, {32'h0, 3'b010}); end
        set_write(4'd3, 32'h0040_0005, lo(20'h12345, 3'd3, 1'b1, 1'b1, 1'b1), lo(20'h00ABC, 3'd2, 1'b0, 1'b1, 1'b1));
        step();
        bus.inst_req = 1; bus.inst_vaddr = 32'h0040_0ABC;
        bus.data_req = 1; bus.data_we = 1; bus.data_vaddr = 32'h0040_1234;
        step();
        nvec++; if (a_inst !== {32'h1234_5ABC, 3'b000}) begin nerr++; $display("[TB] FAIL global_hit: got %h expected %h", a_inst, {32'h1234_5ABC, 3'b000}); end
        nvec++; if (a_data !== {32'h00AB_C234, 4'b1001}) begin nerr++; $display("[TB] FAIL store_modified: got %h expected %h", a_data, {32'h00AB_C234, 4'b1001}); end
        bus.data_req = 1; bus.data_we = 0; bus.data_vaddr = 32'h0040_1234; step();
        nvec++; if (a_data !== {32'h00AB_C234, 4'b1000}) begin nerr++; $display("[TB] FAIL load_clean: got %h expected %h", a_data, {32'h00AB_C234, 4'b1000}); end
    endtask

    task automatic test_hazard_priority();
        set_write(4'd7, 32'h7FFF_E000, lo(20'h00777, 3'd3, 1'b1, 1'b1, 1'b1), lo(20'h00778, 3'd3, 1'b1, 1'b1, 1'b1));
        bus.inst_req = 1; bus.inst_vaddr = 32'h7FFF_E010;
        step();
        nvec++; if (a_inst !== {32'h0, 3'b010}) begin nerr++; $display("[TB] FAIL write_hazard: got %h expected %h", a_inst, {32'h0, 3'b010}); end
        bus.inst_req = 1; bus.inst_vaddr = 32'h7FFF_E010; step();
        nvec++; if (a_inst !== {32'h0077_7010, 3'b000}) begin nerr++; $display("[TB] FAIL after_write: got %h expected %h", a_inst, {32'h0077_7010, 3'b000}); end
        set_write(4'd9, 32'h1000_2006, lo(20'h99999, 3'd3, 1'b1, 1'b1, 1'b0), 32'h0); step();
        set_write(4'd2, 32'h1000_2006, lo(20'h22222, 3'd3, 1'b1, 1'b1, 1'b0), 32'h0); step();
        bus.data_req = 1; bus.data_vaddr = 32'h1000_2044;
        bus.tlbp_en = 1; bus.tlb_entryhi = 32'h1000_2006;
        step();
        nvec++; if (a_data !== {32'h2222_2044, 4'b0000}) begin nerr++; $display("[TB] FAIL dup_lowest: got %h expected %h", a_data, {32'h2222_2044, 4'b0000}); end
        nvec++; if (a_pr !== 5'h02) begin nerr++; $display("[TB] FAIL probe_dup: got %h expected 02", a_pr); end
        bus.tlbp_en = 1; bus.tlb_entryhi = 32'h1000_2007; step();
        nvec++; if (a_pr !== 5'h10) begin nerr++; $display("[TB] FAIL probe_asid: got %h expected 10", a_pr); end
    endtask

    task automatic test_readback();
        bus.tlbr_en = 1; bus.tlbr_idx = 4'd3; step();
        nvec++; if (a_rd !== {32'h0040_0005, lo(20'h12345, 3'd3, 1'b1, 1'b1, 1'b1), lo(20'h00ABC, 3'd2, 1'b0, 1'b1, 1'b1)}) begin
            nerr++; $display("[TB] FAIL tlbr_idx3: got %h expected %h", a_rd, {32'h0040_0005, lo(20'h12345, 3'd3, 1'b1, 1'b1, 1'b1), lo(20'h00ABC, 3'd2, 1'b0, 1'b1, 1'b1)});
        end
        bus.tlbr_en = 1; bus.tlbr_idx = 4'd2; step();
        nvec++; if (a_rd !== {32'h1000_2006, lo(20'h22222, 3'd3, 1'b1, 1'b1, 1'b0), 32'h0}) begin
            nerr++; $display("[TB] FAIL tlbr_idx2: got %h expected %h", a_rd, {32'h1000_2006, lo(20'h22222, 3'd3, 1'b1, 1'b1, 1'b0), 32'h0});
        end
    endtask

    function automatic logic [18:0] rvpn();
        case ($urandom_range(0, 3))
            0:       return 19'h00200;
            1:       return 19'h00201;
            2:       return 19'h3FFFF;
            default: return 19'h60000;
        endcase
    endfunction

    function automatic logic [31:0] raddr();
        case ($urandom_range(0, 5))
            0:       return {3'b100, 29'($urandom)};
            1:       return {3'b101, 29'($urandom)};
            default: return {rvpn(), 13'($urandom)};
        endcase
    endfunction

    task automatic test_random();
        for (int n = 0; n < 250; n++) begin
            bus.cp0_asid = 8'($urandom_range(0, 2));
            bus.cp0_k0   = 3'($urandom_range(1, 3));
            if ($urandom_range(0, 2) == 0)
                set_write(IW'($urandom_range(0, N - 1)), {rvpn(), 5'b0, 8'($urandom_range(0, 2))},
                          $urandom | 32'h3, $urandom | (($urandom_range(0, 1) == 0) ? 32'h1 : 32'h0));
            else
                bus.tlb_entryhi = {rvpn(), 5'b0, 8'($urandom_range(0, 2))};
            bus.inst_req = 1'($urandom_range(0, 1)); bus.inst_vaddr = raddr();
            bus.data_req = 1'($urandom_range(0, 1)); bus.data_vaddr = raddr();
            bus.data_we  = 1'($urandom_range(0, 1));
            bus.tlbr_en  = 1'($urandom_range(0, 1)); bus.tlbr_idx = IW'($urandom_range(0, N - 1));
            bus.tlbp_en  = 1'($urandom_range(0, 1));
            step();
            nvec++; if (a_inst !== e_inst) begin nerr++; $display("[TB] FAIL rand_inst #%0d: got %h expected %h", n, a_inst, e_inst); end
            nvec++; if (a_data !== e_data) begin nerr++; $display("[TB] FAIL rand_data #%0d: got %h expected %h", n, a_data, e_data); end
            nvec++; if (a_rd !== e_rd) begin nerr++; $display("[TB] FAIL rand_tlbr #%0d: got %h expected %h", n, a_rd, e_rd); end
            nvec++; if (a_pr !== e_pr) begin nerr++; $display("[TB] FAIL rand_probe #%0d: got %h expected %h", n, a_pr, e_pr); end
        end
    endtask

    task automatic test_reset_mid();
        set_write(4'd3, 32'h0040_0005, lo(20'h12345, 3'd3, 1'b1, 1'b1, 1'b1), lo(20'h1, 3'd3, 1'b1, 1'b1, 1'b1));
        bus.inst_req = 1; bus.inst_vaddr = 32'hBFC0_0000;
        bus.tlbr_en = 1; bus.tlbr_idx = 4'd0;
        step();
        bus.inst_req = 1; bus.inst_vaddr = 32'h0040_0ABC; bus.tlbp_en = 1; bus.tlb_entryhi = 32'h0040_0005;
        #2 rst_n = 1'b0;
        #1;
        nvec++; if (a_inst !== 35'h0) begin nerr++; $display("[TB] FAIL midrst_inst: got %h expected 0", a_inst); end
        nvec++; if (a_data !== 36'h0) begin nerr++; $display("[TB] FAIL midrst_data: got %h expected 0", a_data); end
        nvec++; if (a_rd !== 96'h0) begin nerr++; $display("[TB] FAIL midrst_tlbr: got %h expected 0", a_rd); end
        nvec++; if (a_pr !== 5'h10) begin nerr++; $display("[TB] FAIL midrst_probe: got %h expected 10", a_pr); end
        model_clear();
        clear_strobes();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        bus.cp0_asid = 8'd5; bus.inst_req = 1; bus.inst_vaddr = 32'h0040_0ABC; step();
        nvec++; if (a_inst !== {32'h0, 3'b010}) begin nerr++; $display("[TB] FAIL midrst_refill: got %h expected %h", a_inst, {32'h0, 3'b010}); end
    endtask

    // Scenario sequence
    initial begin
        clear_strobes();
        bus.inst_vaddr = '0; bus.data_vaddr = '0; bus.cp0_asid = '0; bus.cp0_k0 = 3'd3;
        bus.tlbw_idx = '0; bus.tlb_entryhi = '0; bus.tlb_entrylo0 = '0; bus.tlb_entrylo1 = '0;
        bus.tlbr_idx = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        test_reset();
        test_unmapped();
        test_empty();
        test_write_translate();
        test_asid_global();
        test_hazard_priority();
        test_readback();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
